// File: rtl/cpu_oflow_irq_pkg.sv
// cpu_oflow_irq_pkg
// Shared constants for the overflow interrupt controller: Avalon-MM word
// addresses of the register map and the bus data width.
package cpu_oflow_irq_pkg;

  localparam int DATA_W = 32;

  localparam logic [7:0] ADDR_PENDING    = 8'h00;
  localparam logic [7:0] ADDR_CLEAR      = 8'h01;
  localparam logic [7:0] ADDR_SET        = 8'h02;
  localparam logic [7:0] ADDR_MASK       = 8'h03;
  localparam logic [7:0] ADDR_IRQ_STATUS = 8'h04;
  localparam logic [7:0] ADDR_COUNT_BASE = 8'h10;

endpackage

// File: rtl/cpu_oflow_irq_chan.sv
// cpu_oflow_irq_chan
// One overflow channel: edge detector on the level input, sticky pending bit,
// mask bit, saturating event counter and registered interrupt output.
//
// Ports:
//   clk, reset      rising-edge clock, async active-high reset
//   event_i         level overflow indication
//   set_i, clr_i    software set / clear strobes for the pending bit
//   mask_we_i       mask write strobe, mask_wdata_i the new mask value
//   cnt_clr_i       counter clear strobe
//   pending_o, mask_o, count_o   register state for the read mux
//   irq_o           registered interrupt (pending & mask)
module cpu_oflow_irq_chan #(
  parameter int   CNT_W    = 16,
  parameter logic MASK_RST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             event_i,
  input  logic             set_i,
  input  logic             clr_i,
  input  logic             mask_we_i,
  input  logic             mask_wdata_i,
  input  logic             cnt_clr_i,
  output logic             pending_o,
  output logic             mask_o,
  output logic [CNT_W-1:0] count_o,
  output logic             irq_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             prev_q;
  logic             pending_q, pending_d;
  logic             mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             irq_q, irq_d;
  logic             rise;

  assign rise = event_i & ~prev_q;

  always_comb begin
    // A rise wins over a same-cycle clear so no event is lost.
    pending_d = pending_q;
    if (rise || set_i) begin
      pending_d = 1'b1;
    end else if (clr_i) begin
      pending_d = 1'b0;
    end

    mask_d = mask_we_i ? mask_wdata_i : mask_q;

    // A clear coinciding with a rise leaves that rise counted.
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = rise ? CNT_W'(1) : '0;
    end else if (rise && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Built from next-state values so irq follows the causing edge by one cycle.
    irq_d = pending_d & mask_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q    <= 1'b0;
      pending_q <= 1'b0;
      mask_q    <= MASK_RST;
      cnt_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      prev_q    <= event_i;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
      irq_q     <= irq_d;
    end
  end

  assign pending_o = pending_q;
  assign mask_o    = mask_q;
  assign count_o   = cnt_q;
  assign irq_o     = irq_q;

endmodule

// File: rtl/cpu_oflow_irq_ctrl.sv
// cpu_oflow_irq_ctrl
// Multi-channel overflow interrupt controller with an Avalon-MM slave port.
// Level overflow inputs are edge-detected into sticky pending bits, gated by
// a per-channel mask onto oflow_irq, and counted in saturating counters.
//
// Ports:
//   clk, reset                      clock, async active-high reset
//   avs_address/write/writedata     register write port (word addresses)
//   avs_read, avs_readdata          register read port, readdata latency 1
//   oflow_event[NUM_CH]             level overflow indications
//   oflow_irq[NUM_CH]               registered interrupt per channel
module cpu_oflow_irq_ctrl
  import cpu_oflow_irq_pkg::*;
#(
  parameter int                NUM_CH   = 4,
  parameter int                CNT_W    = 16,
  parameter logic [NUM_CH-1:0] MASK_RST = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        avs_address,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  input  logic              avs_read,
  output logic [DATA_W-1:0] avs_readdata,
  input  logic [NUM_CH-1:0] oflow_event,
  output logic [NUM_CH-1:0] oflow_irq
);

  logic              wr_clear, wr_set, wr_mask;
  logic [NUM_CH-1:0] pending_vec, mask_vec;
  logic [CNT_W-1:0]  cnt_arr [NUM_CH];
  logic [DATA_W-1:0] readdata_q, readdata_d;

  // Write data bits above NUM_CH-1 are ignored by design.
  logic unused_wdata;
  assign unused_wdata = ^avs_writedata;

  assign wr_clear = avs_write && (avs_address == ADDR_CLEAR);
  assign wr_set   = avs_write && (avs_address == ADDR_SET);
  assign wr_mask  = avs_write && (avs_address == ADDR_MASK);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    cpu_oflow_irq_chan #(
      .CNT_W    (CNT_W),
      .MASK_RST (MASK_RST[g])
    ) u_chan (
      .clk          (clk),
      .reset        (reset),
      .event_i      (oflow_event[g]),
      .set_i        (wr_set   && avs_writedata[g]),
      .clr_i        (wr_clear && avs_writedata[g]),
      .mask_we_i    (wr_mask),
      .mask_wdata_i (avs_writedata[g]),
      .cnt_clr_i    (avs_write && (avs_address == ADDR_COUNT_BASE + 8'(g))),
      .pending_o    (pending_vec[g]),
      .mask_o       (mask_vec[g]),
      .count_o      (cnt_arr[g]),
      .irq_o        (oflow_irq[g])
    );
  end

  // Read mux samples current register state, so a same-cycle write is not
  // visible in the returned data. readdata holds when no read is issued.
  always_comb begin
    readdata_d = readdata_q;
    if (avs_read) begin
      readdata_d = '0;
      case (avs_address)
        ADDR_PENDING:    readdata_d[NUM_CH-1:0] = pending_vec;
        ADDR_MASK:       readdata_d[NUM_CH-1:0] = mask_vec;
        ADDR_IRQ_STATUS: readdata_d[NUM_CH-1:0] = pending_vec & mask_vec;
        default: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (avs_address == ADDR_COUNT_BASE + 8'(i)) begin
              readdata_d[CNT_W-1:0] = cnt_arr[i];
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata_q <= '0;
    end else begin
      readdata_q <= readdata_d;
    end
  end

  assign avs_readdata = readdata_q;

endmodule

// File: tb/tb_cpu_oflow_irq_ctrl.sv
// tb_cpu_oflow_irq_ctrl
// Directed bench for cpu_oflow_irq_ctrl (NUM_CH=4, CNT_W=4, MASK_RST=0xA).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_cpu_oflow_irq_ctrl;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 4;
  localparam logic [NUM_CH-1:0] MASK_RST = 4'hA;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        avs_address = '0;
  logic              avs_write = 1'b0;
  logic [31:0]       avs_writedata = '0;
  logic              avs_read = 1'b0;
  logic [31:0]       avs_readdata;
  logic [NUM_CH-1:0] oflow_event = '0;
  logic [NUM_CH-1:0] oflow_irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] rdat;

  always #5 clk = ~clk;

  cpu_oflow_irq_ctrl #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .MASK_RST (MASK_RST)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .oflow_event   (oflow_event),
    .oflow_irq     (oflow_irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    @(negedge clk);
    avs_write     = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_address = a;
    avs_read    = 1'b1;
    @(negedge clk);
    avs_read    = 1'b0;
    d = avs_readdata;
  endtask

  initial begin
    // Reset defaults
    repeat (2) @(negedge clk);
    chk("rst_readdata", avs_readdata, 32'h0);
    chk("rst_irq", 32'(oflow_irq), 32'h0);
    reset = 1'b0;
    rd(8'h00, rdat); chk("rst_pending", rdat, 32'h0);
    rd(8'h03, rdat); chk("rst_mask", rdat, 32'hA);
    rd(8'h10, rdat); chk("rst_count0", rdat, 32'h0);

    // Edge detect / sticky pending
    wr(8'h03, 32'hF);
    @(negedge clk); oflow_event[2] = 1'b1;
    @(negedge clk);
    chk("edge_irq_first", 32'(oflow_irq), 32'h4);
    repeat (9) @(negedge clk);
    chk("edge_irq_held", 32'(oflow_irq), 32'h4);
    rd(8'h00, rdat); chk("edge_pending", rdat, 32'h4);
    rd(8'h12, rdat); chk("edge_count2", rdat, 32'h1);
    wr(8'h01, 32'h4);
    chk("w1c_irq", 32'(oflow_irq), 32'h0);
    rd(8'h00, rdat); chk("w1c_pending", rdat, 32'h0);
    oflow_event[2] = 1'b0;

    // Rise coinciding with W1C of the same bit
    @(negedge clk); oflow_event[1] = 1'b1;
    @(negedge clk); oflow_event[1] = 1'b0;
    @(negedge clk);
    oflow_event[1] = 1'b1;
    avs_address = 8'h01; avs_writedata = 32'h2; avs_write = 1'b1;
    @(negedge clk);
    oflow_event[1] = 1'b0; avs_write = 1'b0;
    rd(8'h00, rdat); chk("race_pending", rdat, 32'h2);
    rd(8'h11, rdat); chk("race_count1", rdat, 32'h2);
    chk("race_irq", 32'(oflow_irq), 32'h2);

    // Mask and software SET
    wr(8'h01, 32'hF);
    wr(8'h03, 32'h0);
    wr(8'h02, 32'h1);
    rd(8'h00, rdat); chk("set_pending", rdat, 32'h1);
    chk("set_irq_masked", 32'(oflow_irq), 32'h0);
    rd(8'h04, rdat); chk("set_status_masked", rdat, 32'h0);
    wr(8'h03, 32'h1);
    chk("unmask_irq", 32'(oflow_irq), 32'h1);
    rd(8'h04, rdat); chk("unmask_status", rdat, 32'h1);
    rd(8'h10, rdat); chk("set_no_count", rdat, 32'h0);

    // Counter saturation and clear
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); oflow_event[3] = 1'b1;
      @(negedge clk); oflow_event[3] = 1'b0;
    end
    rd(8'h13, rdat); chk("sat_count3", rdat, 32'hF);
    wr(8'h13, 32'h0);
    rd(8'h13, rdat); chk("cnt_clr", rdat, 32'h0);
    @(negedge clk);
    oflow_event[3] = 1'b1;
    avs_address = 8'h13; avs_writedata = 32'h0; avs_write = 1'b1;
    @(negedge clk);
    oflow_event[3] = 1'b0; avs_write = 1'b0;
    rd(8'h13, rdat); chk("cnt_clr_rise", rdat, 32'h1);
    chk("sat_irq", 32'(oflow_irq), 32'h1);

    // Read latency, unmapped, back-to-back, read+write same cycle
    rd(8'h05, rdat); chk("unmapped", rdat, 32'h0);
    rd(8'h01, rdat); chk("clear_reads0", rdat, 32'h0);
    @(negedge clk);
    avs_address = 8'h00; avs_read = 1'b1;
    @(negedge clk);
    chk("b2b_first", avs_readdata, 32'h9);
    avs_address = 8'h03;
    @(negedge clk);
    avs_read = 1'b0;
    chk("b2b_second", avs_readdata, 32'h1);
    @(negedge clk);
    chk("readdata_hold", avs_readdata, 32'h1);
    @(negedge clk);
    avs_address = 8'h03; avs_writedata = 32'h6; avs_read = 1'b1; avs_write = 1'b1;
    @(negedge clk);
    avs_read = 1'b0; avs_write = 1'b0;
    chk("rw_old_value", avs_readdata, 32'h1);
    rd(8'h03, rdat); chk("rw_new_mask", rdat, 32'h6);
    chk("rw_irq", 32'(oflow_irq), 32'h0);

    // Reset mid-traffic with an input held high through deassertion
    rd(8'h00, rdat); chk("pre_rst_pending", rdat, 32'h9);
    @(negedge clk); oflow_event[0] = 1'b1;
    @(negedge clk); reset = 1'b1;
    #1;
    chk("mid_rst_readdata", avs_readdata, 32'h0);
    chk("mid_rst_irq", 32'(oflow_irq), 32'h0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk("post_rst_irq", 32'(oflow_irq), 32'h0);
    rd(8'h00, rdat); chk("post_rst_pending", rdat, 32'h1);
    rd(8'h03, rdat); chk("post_rst_mask", rdat, 32'hA);
    rd(8'h10, rdat); chk("post_rst_count0", rdat, 32'h1);
    rd(8'h13, rdat); chk("post_rst_count3", rdat, 32'h0);
    oflow_event[0] = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
